laser_event_detect: RTL and testbench

- Sits directly downstream of the laser low-pass stage and consumes its filtered sample stream (lp_laser_vld / lp_laser_data).
- Detects pulse events with hysteresis thresholds and records, per event:
  - peak amplitude
  - peak offset within the event
  - width in samples
  - start timestamp
- Applies a post-event holdoff and a minimum-width filter, then presents one registered event record per qualified pulse to the PMT packing logic.

---
 rtl/laser_event_detect.sv | 212 +++++++++++++++++++++
 tb/tb_laser_event_detect.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_event_detect.sv
// Purpose: hysteresis pulse detector on the filtered laser stream; emits one peak/pos/width/ts record per qualified pulse.
// Latency: event_vld_o rises on the cycle after the edge that accepts the sample ending the pulse.
// Backpressure: none; accepts one sample per clock and always runs at input rate.
module laser_event_detect #(
  parameter real TCQ        = 0.1,
  parameter int  DATA_WIDTH = 16,
  parameter int  CNT_WIDTH  = 16,
  parameter int  HOLD_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_en_i,
  input  logic [DATA_WIDTH-1:0] cfg_thr_hi_i,
  input  logic [DATA_WIDTH-1:0] cfg_thr_lo_i,
  input  logic [CNT_WIDTH-1:0]  cfg_min_width_i,
  input  logic [HOLD_WIDTH-1:0] cfg_holdoff_i,
  input  logic                  lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0] lp_laser_data_i,
  output logic                  event_vld_o,
  output logic [DATA_WIDTH-1:0] event_peak_o,
  output logic [CNT_WIDTH-1:0]  event_peak_pos_o,
  output logic [CNT_WIDTH-1:0]  event_width_o,
  output logic [CNT_WIDTH-1:0]  event_ts_o,
  output logic                  event_sat_o,
  output logic                  busy_o
);

  // TCQ is a clock-to-q delay used only by behavioural models; this
  // block is purely synthesizable, so it only guards against nonsense values.
  if (TCQ < 0.0) begin : g_tcq_invalid
    logic tcq_invalid_unused;
  end

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX_M1 = CNT_MAX - CNT_ONE;
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE   = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ABOVE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // free-running sample timestamp
  logic [CNT_WIDTH-1:0]  sample_cnt;

  // in-flight event tracking
  logic [CNT_WIDTH-1:0]  width_q;
  logic [DATA_WIDTH-1:0] peak_q;
  logic [CNT_WIDTH-1:0]  pos_q;
  logic [CNT_WIDTH-1:0]  ts_q;
  logic                  sat_q;

  // configuration captured when an event opens
  logic [CNT_WIDTH-1:0]  min_width_q;
  logic [HOLD_WIDTH-1:0] holdoff_q;

  // remaining samples to ignore after a reported event
  logic [HOLD_WIDTH-1:0] hcnt_q;

  // per-sample decisions from the FSM
  logic evt_start;
  logic evt_grow;
  logic evt_emit;
  logic hold_dec;

  logic above_hi;
  logic below_lo;
  logic width_ok;
  logic new_peak;

  // thresholds are compared live; min width uses the value latched at start
  assign above_hi = (lp_laser_data_i >= cfg_thr_hi_i);
  assign below_lo = (lp_laser_data_i <  cfg_thr_lo_i);
  assign width_ok = (width_q >= min_width_q);
  assign new_peak = (lp_laser_data_i >  peak_q);

  assign busy_o = (state != IDLE);

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and per-sample action decode; disable wins over everything
  always_comb begin
    state_nxt = state;
    evt_start = 1'b0;
    evt_grow  = 1'b0;
    evt_emit  = 1'b0;
    hold_dec  = 1'b0;
    if (!cfg_en_i) begin
      state_nxt = IDLE;
    end else if (lp_laser_vld_i) begin
      case (state)
        IDLE: begin
          if (above_hi) begin
            evt_start = 1'b1;
            state_nxt = ABOVE;
          end
        end
        ABOVE: begin
          if (below_lo) begin
            if (width_ok) begin
              evt_emit  = 1'b1;
              state_nxt = (holdoff_q == '0) ? IDLE : HOLDOFF;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            evt_grow = 1'b1;
          end
        end
        HOLDOFF: begin
          hold_dec = 1'b1;
          if (hcnt_q <= HOLD_ONE) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // timestamp counter: counts accepted samples, parked at zero while disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_cnt <= '0;
    end else if (!cfg_en_i) begin
      sample_cnt <= '0;
    end else if (lp_laser_vld_i) begin
      sample_cnt <= sample_cnt + CNT_ONE;
    end
  end

  // event accumulator: open on start, track first peak and saturating width
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      width_q     <= '0;
      peak_q      <= '0;
      pos_q       <= '0;
      ts_q        <= '0;
      sat_q       <= 1'b0;
      min_width_q <= '0;
      holdoff_q   <= '0;
    end else if (evt_start) begin
      width_q     <= CNT_ONE;
      peak_q      <= lp_laser_data_i;
      pos_q       <= '0;
      ts_q        <= sample_cnt;
      sat_q       <= 1'b0;
      min_width_q <= cfg_min_width_i;
      holdoff_q   <= cfg_holdoff_i;
    end else if (evt_grow) begin
      if (new_peak) begin
        peak_q <= lp_laser_data_i;
        pos_q  <= width_q;
      end
      if (width_q != CNT_MAX) begin
        width_q <= width_q + CNT_ONE;
      end
      if (width_q >= CNT_MAX_M1) begin
        sat_q <= 1'b1;
      end
    end
  end

  // holdoff countdown: armed by a reported event, stepped by each held sample
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hcnt_q <= '0;
    end else if (!cfg_en_i) begin
      hcnt_q <= '0;
    end else if (evt_emit) begin
      hcnt_q <= holdoff_q;
    end else if (hold_dec) begin
      hcnt_q <= hcnt_q - HOLD_ONE;
    end
  end

  // output record: one-cycle strobe, fields hold until the next report
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      event_vld_o      <= 1'b0;
      event_peak_o     <= '0;
      event_peak_pos_o <= '0;
      event_width_o    <= '0;
      event_ts_o       <= '0;
      event_sat_o      <= 1'b0;
    end else begin
      event_vld_o <= evt_emit;
      if (evt_emit) begin
        event_peak_o     <= peak_q;
        event_peak_pos_o <= pos_q;
        event_width_o    <= width_q;
        event_ts_o       <= ts_q;
        event_sat_o      <= sat_q;
      end
    end
  end

endmodule

// File: tb/tb_laser_event_detect.sv
// Purpose: scoreboard bench for laser_event_detect; two instances (16-bit and 4-bit counters) share one stimulus.
// Latency: expected records are stamped with the cycle after the terminating sample is accepted.
// Backpressure: none; the monitor pops an expectation every time event_vld_o is seen.
module tb_laser_event_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [15:0] thr_hi;
  logic [15:0] thr_lo;
  logic [15:0] min_width;
  logic [7:0]  holdoff;
  logic        vld;
  logic [15:0] data;

  logic        a_vld, a_sat, a_busy;
  logic [15:0] a_peak, a_pos, a_width, a_ts;
  logic        b_vld, b_sat, b_busy;
  logic [15:0] b_peak;
  logic [3:0]  b_pos, b_width, b_ts;

  laser_event_detect #(.DATA_WIDTH(16), .CNT_WIDTH(16), .HOLD_WIDTH(8)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_en_i(en),
    .cfg_thr_hi_i(thr_hi), .cfg_thr_lo_i(thr_lo),
    .cfg_min_width_i(min_width), .cfg_holdoff_i(holdoff),
    .lp_laser_vld_i(vld), .lp_laser_data_i(data),
    .event_vld_o(a_vld), .event_peak_o(a_peak), .event_peak_pos_o(a_pos),
    .event_width_o(a_width), .event_ts_o(a_ts), .event_sat_o(a_sat),
    .busy_o(a_busy)
  );

  laser_event_detect #(.DATA_WIDTH(16), .CNT_WIDTH(4), .HOLD_WIDTH(8)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_en_i(en),
    .cfg_thr_hi_i(thr_hi), .cfg_thr_lo_i(thr_lo),
    .cfg_min_width_i(min_width[3:0]), .cfg_holdoff_i(holdoff),
    .lp_laser_vld_i(vld), .lp_laser_data_i(data),
    .event_vld_o(b_vld), .event_peak_o(b_peak), .event_peak_pos_o(b_pos),
    .event_width_o(b_width), .event_ts_o(b_ts), .event_sat_o(b_sat),
    .busy_o(b_busy)
  );

  typedef struct packed {
    logic [15:0] peak;
    logic [15:0] pos;
    logic [15:0] width;
    logic [15:0] ts;
    logic        sat;
    int unsigned cyc;
  } rec_t;

  rec_t exp_a[$];
  rec_t exp_b[$];

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an event is the list of samples between crossing thr_hi
  // and the first sample below thr_lo; stats are computed from that list.
  bit in_evt[2];
  int hold_left[2];
  int ts_cnt[2];
  int ev_ts[2];
  int ev_minw[2];
  int ev_hold[2];
  int ev_len[2];
  int ev_dat[2][64];

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      in_evt[u]    = 1'b0;
      hold_left[u] = 0;
      ts_cnt[u]    = 0;
    end
  endtask

  task automatic model_step(input int d);
    for (int u = 0; u < 2; u++) begin
      int maxv;
      maxv = (u == 0) ? 65535 : 15;
      if (in_evt[u]) begin
        if (d < int'(thr_lo)) begin
          int w;
          w = (ev_len[u] > maxv) ? maxv : ev_len[u];
          in_evt[u] = 1'b0;
          if (w >= ev_minw[u]) begin
            rec_t r;
            int best;
            best = 0;
            for (int i = 1; i < ev_len[u] && i < 64; i++)
              if (ev_dat[u][i] > ev_dat[u][best]) best = i;
            r.peak  = 16'(ev_dat[u][best]);
            r.pos   = 16'((best > maxv) ? maxv : best);
            r.width = 16'(w);
            r.ts    = 16'(ev_ts[u]);
            r.sat   = (ev_len[u] >= maxv);
            r.cyc   = cyc + 1;
            if (u == 0) exp_a.push_back(r);
            else        exp_b.push_back(r);
            hold_left[u] = ev_hold[u];
          end
        end else begin
          if (ev_len[u] < 64) ev_dat[u][ev_len[u]] = d;
          ev_len[u]++;
        end
      end else if (hold_left[u] > 0) begin
        hold_left[u]--;
      end else if (d >= int'(thr_hi)) begin
        in_evt[u]    = 1'b1;
        ev_len[u]    = 1;
        ev_dat[u][0] = d;
        ev_ts[u]     = ts_cnt[u];
        ev_minw[u]   = int'(min_width) & maxv;
        ev_hold[u]   = int'(holdoff);
      end
      ts_cnt[u] = (ts_cnt[u] + 1) & maxv;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_busy(input string tag);
    check({tag, "_busy_a"}, 32'(a_busy), 32'(in_evt[0] || hold_left[0] > 0));
    check({tag, "_busy_b"}, 32'(b_busy), 32'(in_evt[1] || hold_left[1] > 0));
  endtask

  task automatic check_drain(input string tag);
    check({tag, "_pending_a"}, 32'(exp_a.size()), 32'd0);
    check({tag, "_pending_b"}, 32'(exp_b.size()), 32'd0);
  endtask

  // monitor: pop and compare whenever a DUT presents a record
  always @(negedge clk) begin : mon
    rec_t r;
    if (a_vld === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL event_a: unexpected record peak=%0d width=%0d ts=%0d at cyc %0d",
                 a_peak, a_width, a_ts, cyc);
      end else begin
        r = exp_a.pop_front();
        if ({a_peak, a_pos, a_width, a_ts, a_sat} !== {r.peak, r.pos, r.width, r.ts, r.sat} ||
            cyc != r.cyc) begin
          errors++;
          $display("FAIL event_a: got peak=%0d pos=%0d width=%0d ts=%0d sat=%0d cyc=%0d, expected peak=%0d pos=%0d width=%0d ts=%0d sat=%0d cyc=%0d",
                   a_peak, a_pos, a_width, a_ts, a_sat, cyc, r.peak, r.pos, r.width, r.ts, r.sat, r.cyc);
        end
      end
    end
    if (b_vld === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL event_b: unexpected record peak=%0d width=%0d ts=%0d at cyc %0d",
                 b_peak, b_width, b_ts, cyc);
      end else begin
        r = exp_b.pop_front();
        if ({b_peak, 12'd0, b_pos, 12'd0, b_width, 12'd0, b_ts, b_sat} !==
            {r.peak, r.pos, r.width, r.ts, r.sat} || cyc != r.cyc) begin
          errors++;
          $display("FAIL event_b: got peak=%0d pos=%0d width=%0d ts=%0d sat=%0d cyc=%0d, expected peak=%0d pos=%0d width=%0d ts=%0d sat=%0d cyc=%0d",
                   b_peak, b_pos, b_width, b_ts, b_sat, cyc, r.peak, r.pos, r.width, r.ts, r.sat, r.cyc);
        end
      end
    end
  end

  task automatic send(input int d, input int gap);
    repeat (gap) begin
      @(negedge clk);
      vld  = 1'b0;
      data = 16'($urandom);
    end
    @(negedge clk);
    vld  = 1'b1;
    data = 16'(d);
    if (en) model_step(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  // drop enable briefly so each scenario starts from IDLE with sample_cnt=0
  task automatic restart();
    @(negedge clk);
    vld = 1'b0;
    en  = 1'b0;
    model_clear();
    @(negedge clk);
    en  = 1'b1;
  endtask

  task automatic base_cfg();
    thr_hi    = 16'd100;
    thr_lo    = 16'd80;
    min_width = 16'd3;
    holdoff   = 8'd2;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    vld   = 1'b0;
    data  = '0;
    base_cfg();
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_vld_a",   32'(a_vld),   32'd0);
    check("rst_peak_a",  32'(a_peak),  32'd0);
    check("rst_width_a", 32'(a_width), 32'd0);
    check("rst_ts_a",    32'(a_ts),    32'd0);
    check("rst_busy_a",  32'(a_busy),  32'd0);
    check("rst_vld_b",   32'(b_vld),   32'd0);
    rst_n = 1'b1;

    // basic event
    restart(); base_cfg();
    send(50, 0); send(120, 0); send(150, 0); send(130, 0); send(70, 0);
    idle(1); check_busy("basic");
    idle(4); check_drain("basic");

    // short pulse, discarded
    restart(); base_cfg();
    send(120, 0); send(130, 0); send(70, 0);
    idle(2);
    check("short_busy_a", 32'(a_busy), 32'd0);
    check_drain("short");

    // hysteresis: dips between thresholds keep the event open
    restart(); base_cfg();
    send(120, 0); send(90, 0); send(85, 0); send(110, 0); send(79, 0);
    idle(5); check_drain("hyst");

    // holdoff with random valid gaps
    restart(); base_cfg();
    send(120, $urandom_range(0, 3)); send(130, $urandom_range(0, 3));
    send(140, $urandom_range(0, 3)); send(50,  $urandom_range(0, 3));
    send(200, $urandom_range(0, 3)); send(200, $urandom_range(0, 3));
    send(200, $urandom_range(0, 3)); send(150, $urandom_range(0, 3));
    send(90,  $urandom_range(0, 3)); send(60,  $urandom_range(0, 3));
    idle(6); check_drain("holdoff"); check_busy("holdoff");

    // saturation: 4-bit instance clamps at 15
    restart(); base_cfg(); min_width = 16'd1;
    for (int i = 0; i < 20; i++) send(200, 0);
    send(0, 0);
    idle(5); check_drain("sat");

    // thr_lo above thr_hi: width-1 event
    restart(); base_cfg(); thr_lo = 16'd150; min_width = 16'd1;
    send(120, 0); send(50, 0);
    idle(5); check_drain("misconf");

    // reset mid-event
    restart(); base_cfg();
    send(120, 0); send(130, 0); send(140, 0);
    @(negedge clk);
    vld   = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_peak_a",  32'(a_peak),  32'd0);
    check("midrst_width_a", 32'(a_width), 32'd0);
    check("midrst_busy_a",  32'(a_busy),  32'd0);
    check("midrst_busy_b",  32'(b_busy),  32'd0);
    send(50, 0); send(120, 0); send(150, 0); send(130, 0); send(70, 0);
    idle(5); check_drain("midrst");

    // enable drop mid-event
    restart(); base_cfg();
    send(120, 0); send(130, 0);
    @(negedge clk);
    vld = 1'b0;
    en  = 1'b0;
    model_clear();
    send(70, 0); send(60, 0);
    idle(1);
    check("endrop_busy_a", 32'(a_busy), 32'd0);
    check("endrop_cnt_a",  32'(u_a.sample_cnt), 32'd0);
    check("endrop_cnt_b",  32'(u_b.sample_cnt), 32'd0);
    en = 1'b1;
    idle(4); check_drain("endrop");

    // randomized stream with occasional reconfiguration
    restart(); base_cfg();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        vld       = 1'b0;
        thr_hi    = 16'($urandom_range(60, 200));
        thr_lo    = 16'($urandom_range(40, int'(thr_hi) + 20));
        min_width = 16'($urandom_range(0, 4));
        holdoff   = 8'($urandom_range(0, 3));
      end
      send($urandom_range(0, 255), $urandom_range(0, 2));
    end
    idle(3); check_busy("rand");
    idle(5); check_drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
